seq_multiplier_4bit: RTL and testbench
======================================

SEQ_MULTIPLIER_4BIT -- requirements
Module: seq_multiplier_4bit

Interface
REQ-001 Parameters: none; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 A  input  4  multiplicand, unsigned; captured on the accepting edge.
REQ-006 B  input  4  multiplier, unsigned; captured on the accepting edge.
REQ-007 busy  output  1  high while a multiply is in progress (CALC state).
REQ-008 done  output  1  one-cycle pulse; P holds a new product.
REQ-009 P  output  8  registered unsigned product A*B; held until the next completion.

Function
REQ-010 FSM states SHALL be IDLE, CALC and DONE.
REQ-011 IDLE with start=1 at edge k: capture mcand<=A, acc_lo<=B, acc_hi<=0, cnt<=0; go to CALC.
REQ-012 IDLE with start=0: remain in IDLE; all registers hold.
REQ-013 Each CALC edge: {Cout,Sum} = acc_hi + (acc_lo[0] ? mcand : 0) with carry-in 0; {acc_hi,acc_lo} <= {Cout,Sum,acc_lo[3:1]}; cnt <= cnt+1.
REQ-014 CALC SHALL last exactly 4 edges (k+1..k+4); on edge k+4 (cnt==3), P <= final {acc_hi,acc_lo} and state <= DONE.
REQ-015 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-016 done=1 exactly in DONE (cycle after edge k+4); busy=1 exactly in CALC; both are decoded from state.
REQ-017 start asserted in CALC or DONE SHALL be ignored: no capture, no restart, no queuing.
REQ-018 Earliest next acceptance SHALL be the edge after DONE (back-to-back throughput one multiply per 6 cycles).
REQ-019 A and B changes after acceptance SHALL NOT affect the in-flight result.
REQ-020 P SHALL change only on the edge entering DONE or on reset; no intermediate values visible.
REQ-021 Arithmetic: unsigned only; 4-bit adder with carry-out provides the 5th bit; product never overflows 8 bits (max 15*15=225).
REQ-022 Zero operands SHALL take the full 4-cycle latency (no early termination).

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, P=8'h00, acc_hi=acc_lo=mcand=0, cnt=0, regardless of clock.
REQ-024 Reset mid-CALC SHALL abort the operation; no done pulse is issued for it and P reads 0.
REQ-025 After rst_n deasserts, start SHALL be accepted on the first rising edge at which it is high.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE/CALC/DONE, 2 bits) and the constant ITERATIONS=4.
REQ-027 The per-iteration add SHALL instantiate the existing ripple_carry_adder_4bit as the single sub-module, Cin tied to 0.
REQ-028 The partial-product mux, shift register, counter and FSM SHALL reside in seq_multiplier_4bit.

Verification
REQ-029 A=15, B=15, start pulse at edge k -> busy 1 for 4 cycles, done pulse after edge k+4, P=8'hE1 (225).
REQ-030 A=3, B=5 -> P=8'h0F; then A=0, B=9 -> P=8'h00 with the same 4-cycle latency.
REQ-031 A=7, B=6 accepted, then start held high with A=2, B=2 during CALC -> single done, P=8'h2A; next multiply (4) begins only after DONE.
REQ-032 A=9, B=11 accepted, rst_n low at edge k+2 -> busy=0, P=0, no done pulse; after release, A=1, B=1 -> P=8'h01.
REQ-033 Exhaustive 256-pair sweep, back-to-back starts -> every P equals A*B, one done pulse per request, 6-cycle spacing.

Source files
------------

// File: rtl/seq_multiplier_4bit_pkg.sv
// Shared definitions for the 4-bit shift-and-add multiplier:
// FSM state encoding and iteration count.
package seq_multiplier_4bit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned ITERATIONS = 4;

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder built from a chain of full-adder bit slices.
module ripple_carry_adder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        Sum      = '0;
        carry[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]     = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        Cout = carry[4];
    end

endmodule

// File: rtl/seq_multiplier_4bit.sv
// Sequential 4x4 unsigned multiplier: one shift-and-add step per CALC cycle,
// product registered on entry to DONE and held until the next completion.
module seq_multiplier_4bit
    import seq_multiplier_4bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [7:0] P
);

    localparam logic [1:0] CntLast = 2'(ITERATIONS - 1);

    state_e     state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] acc_hi_q, acc_hi_d;
    logic [3:0] acc_lo_q, acc_lo_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] p_q, p_d;

    logic [3:0] addend;
    logic [3:0] add_sum;
    logic       add_cout;
    logic [7:0] shifted;

    // Partial product is the multiplicand gated by the current multiplier LSB.
    assign addend  = mcand_q & {4{acc_lo_q[0]}};
    assign shifted = {add_cout, add_sum, acc_lo_q[3:1]};

    ripple_carry_adder_4bit u_adder (
        .A    (acc_hi_q),
        .B    (addend),
        .Cin  (1'b0),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = A;
                    acc_lo_d = B;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                {acc_hi_d, acc_lo_d} = shifted;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == CntLast) begin
                    p_d     = shifted;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign busy = (state_q == StCalc);
    assign done = (state_q == StDone);
    assign P    = p_q;

endmodule

// File: tb/tb_seq_multiplier_4bit.sv
// Self-checking bench for seq_multiplier_4bit: directed cases, random pairs and
// an exhaustive back-to-back sweep checked against plain A*B with fixed timing.
module tb_seq_multiplier_4bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;

    int unsigned n_total;
    int unsigned n_pass;
    logic [7:0]  p_exp;

    seq_multiplier_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and check the full 6-cycle transaction.
    // hold keeps start high after acceptance; operands are scrambled regardless.
    task automatic do_mult(input logic [3:0] a, input logic [3:0] b, input bit hold);
        logic [7:0] prod;
        prod  = 8'(a) * 8'(b);
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = hold;
        A     = 4'($urandom);
        B     = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            check("calc_busy", {7'd0, busy}, 8'd1);
            check("calc_done", {7'd0, done}, 8'd0);
            check("calc_p_hold", P, p_exp);
            A = 4'($urandom);
            B = 4'($urandom);
            tick();
        end
        p_exp = prod;
        check("done_pulse", {7'd0, done}, 8'd1);
        check("done_busy", {7'd0, busy}, 8'd0);
        check("done_p", P, p_exp);
        tick();
        check("idle_done", {7'd0, done}, 8'd0);
        check("idle_busy", {7'd0, busy}, 8'd0);
        check("idle_p", P, p_exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        p_exp   = 8'h00;
        rst_n   = 1'b0;
        start   = 1'b0;
        A       = 4'h0;
        B       = 4'h0;
        #1;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_p", P, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Idle with start low: nothing moves.
        A = 4'hF;
        B = 4'hF;
        repeat (3) begin
            tick();
            check("idle_hold_busy", {7'd0, busy}, 8'd0);
            check("idle_hold_p", P, 8'h00);
        end

        do_mult(4'd15, 4'd15, 1'b0);
        check("p_225", P, 8'hE1);
        do_mult(4'd3, 4'd5, 1'b0);
        check("p_15", P, 8'h0F);
        do_mult(4'd0, 4'd9, 1'b0);
        check("p_zero", P, 8'h00);

        // Start held through CALC/DONE is ignored; next request starts after DONE.
        do_mult(4'd7, 4'd6, 1'b1);
        check("p_42", P, 8'h2A);
        do_mult(4'd2, 4'd2, 1'b0);
        check("p_4", P, 8'h04);

        // Reset in the middle of CALC aborts with no done pulse.
        A     = 4'd9;
        B     = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        p_exp = 8'h00;
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_done", {7'd0, done}, 8'd0);
        check("abort_p", P, 8'h00);
        repeat (5) begin
            tick();
            check("abort_no_done", {7'd0, done}, 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        do_mult(4'd1, 4'd1, 1'b0);
        check("p_1", P, 8'h01);

        for (int n = 0; n < 20; n++) begin
            do_mult(4'($urandom), 4'($urandom), 1'($urandom));
            start = 1'b0;
        end

        // Exhaustive sweep, each request issued the cycle after the previous DONE.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_mult(4'(i), 4'(j), 1'b0);
            end
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
